// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - March-style BIST initiator for a single-port sync-read RAM
//
// Purpose:
//   Takes ownership of the RAM port while busy and runs three phases:
//   write background P, read/compare P then write ~P per address,
//   read/compare ~P. Reports pass, mismatch count and first failing address.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   start, pattern     test request (sampled in IDLE/DONE) and background word
//   ram_address/ram_data_in/ram_write_en   registered RAM command outputs
//   ram_data_out       RAM read data, valid 1 edge after the address is sampled
//   busy, done, pass   status; pass valid while done=1
//   fail_count         saturating count of mismatching reads
//   fail_addr          address of the first mismatch (0 if none)
//
// Optional feature (macro RAM_BIST_STOP_ON_FAIL_EN):
//   stop issuing operations after the first mismatch, drain, report one failure.

module ram_bist_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int FAIL_CNT_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     pattern,
    output logic [ADDR_WIDTH-1:0]     ram_address,
    output logic [DATA_WIDTH-1:0]     ram_data_in,
    output logic                      ram_write_en,
    input  logic [DATA_WIDTH-1:0]     ram_data_out,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]     fail_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_BG,
        ST_RD_BG,
        ST_RD_CMP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // state/addr/rd_wr_phase describe the operation to issue at the next edge
    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr, addr_n;
    logic                    rd_wr_phase, rd_wr_phase_n;  // RD_BG: 0 = read, 1 = write
    logic [DATA_WIDTH-1:0]   pat;

    // Compare pipeline: stage 1 = RAM sampling the address, stage 2 = data returned
    logic                    s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0]   s1_exp, s2_exp;
    logic [ADDR_WIDTH-1:0]   s1_addr, s2_addr;

    logic                    op_issue;
    logic                    op_we;
    logic                    op_cmp;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [DATA_WIDTH-1:0]   op_data;
    logic [DATA_WIDTH-1:0]   op_exp;
    logic                    start_accept;
    logic                    finish;

    logic                    mismatch;
    logic                    count_en;

    // Case inequality so that X/Z read data is reported as a failure
    assign mismatch = s2_valid && (ram_data_out !== s2_exp);

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    // Only the first mismatch is counted; anything still in the pipe is ignored
    assign count_en = mismatch && (fail_count == '0);
`else
    assign count_en = mismatch;
`endif

    always_comb begin
        state_n       = state;
        addr_n        = addr;
        rd_wr_phase_n = rd_wr_phase;
        op_issue      = 1'b0;
        op_we         = 1'b0;
        op_cmp        = 1'b0;
        op_addr       = addr;
        op_data       = pat;
        op_exp        = pat;
        start_accept  = 1'b0;
        finish        = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // The first background write goes out on the accepting edge
                    start_accept = 1'b1;
                    op_issue     = 1'b1;
                    op_we        = 1'b1;
                    op_addr      = '0;
                    op_data      = pattern;
                    state_n      = ST_W_BG;
                    addr_n       = ADDR_WIDTH'(1);
                end
            end
            ST_W_BG: begin
                op_issue = 1'b1;
                op_we    = 1'b1;
                if (addr == LAST_ADDR) begin
                    state_n       = ST_RD_BG;
                    addr_n        = '0;
                    rd_wr_phase_n = 1'b0;
                end else begin
                    addr_n = addr + 1'b1;
                end
            end
            ST_RD_BG: begin
                op_issue = 1'b1;
                if (!rd_wr_phase) begin
                    op_cmp        = 1'b1;
                    rd_wr_phase_n = 1'b1;
                end else begin
                    op_we         = 1'b1;
                    op_data       = ~pat;
                    rd_wr_phase_n = 1'b0;
                    if (addr == LAST_ADDR) begin
                        state_n = ST_RD_CMP;
                        addr_n  = '0;
                    end else begin
                        addr_n = addr + 1'b1;
                    end
                end
            end
            ST_RD_CMP: begin
                op_issue = 1'b1;
                op_cmp   = 1'b1;
                op_exp   = ~pat;
                if (addr == LAST_ADDR) begin
                    state_n = ST_DRAIN;
                    addr_n  = '0;
                end else begin
                    addr_n = addr + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Leave once the last queued compare has retired
                if (!s1_valid && !s2_valid) begin
                    state_n = ST_DONE;
                    finish  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

`ifdef RAM_BIST_STOP_ON_FAIL_EN
        if (mismatch && (fail_count == '0) &&
            (state == ST_W_BG || state == ST_RD_BG || state == ST_RD_CMP)) begin
            state_n = ST_DRAIN;
            addr_n  = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            addr         <= '0;
            rd_wr_phase  <= 1'b0;
            pat          <= '0;
            ram_address  <= '0;
            ram_data_in  <= '0;
            ram_write_en <= 1'b0;
            s1_valid     <= 1'b0;
            s1_exp       <= '0;
            s1_addr      <= '0;
            s2_valid     <= 1'b0;
            s2_exp       <= '0;
            s2_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_count   <= '0;
            fail_addr    <= '0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            rd_wr_phase <= rd_wr_phase_n;

            if (op_issue) begin
                ram_address  <= op_addr;
                ram_write_en <= op_we;
                if (op_we) begin
                    ram_data_in <= op_data;
                end
            end else begin
                ram_write_en <= 1'b0;
            end

            s1_valid <= op_issue && op_cmp;
            s1_exp   <= op_exp;
            s1_addr  <= op_addr;
            s2_valid <= s1_valid;
            s2_exp   <= s1_exp;
            s2_addr  <= s1_addr;

            if (start_accept) begin
                pat        <= pattern;
                fail_count <= '0;
                fail_addr  <= '0;
                pass       <= 1'b0;
                busy       <= 1'b1;
                done       <= 1'b0;
            end else if (count_en) begin
                if (fail_count == '0) begin
                    fail_addr <= s2_addr;
                end
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
            end

            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (fail_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - self-checking bench for ram_bist_ctrl with a faulty-RAM model

module tb_ram_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int FW = 6;
    localparam int N  = 16;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_MODE = 1'b1;
`else
    localparam bit STOP_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] pattern;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_write_en;
    logic [DW-1:0] ram_data_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [FW-1:0] fail_count;
    logic [AW-1:0] fail_addr;

    logic [DW-1:0] mem   [N];
    logic [DW-1:0] rmask [N];
    int            writes = 0;

    int checks   = 0;
    int failures = 0;

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIL_CNT_WIDTH(FW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pattern      (pattern),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
        .ram_data_out (ram_data_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_count   (fail_count),
        .fail_addr    (fail_addr)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: read-first synchronous read, fault masks applied on read only
    always @(posedge clk) begin
        if (ram_write_en) begin
            mem[ram_address] <= ram_data_in;
            writes <= writes + 1;
        end
        ram_data_out <= mem[ram_address] & rmask[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outcome straight from the test rules: every address is read once
    // expecting P (phase 2) and once expecting ~P (phase 3), phase 2 first.
    task automatic model(input logic [DW-1:0] p, output int fc, output int fa);
        logic [DW-1:0] np;
        bit first;
        np = ~p;
        fc = 0;
        fa = 0;
        first = 1'b1;
        for (int a = 0; a < N; a++) begin
            if ((p & rmask[a]) != p) begin
                fc++;
                if (first) fa = a;
                first = 1'b0;
            end
        end
        for (int a = 0; a < N; a++) begin
            if ((np & rmask[a]) != np) begin
                fc++;
                if (first) fa = a;
                first = 1'b0;
            end
        end
    endtask

    // Called #1 after an edge. Returns edges from the accepting edge to done.
    // intrude_at > 0 pulses start with 8'hFF so that it is sampled at S+intrude_at.
    task automatic run_bist(input logic [DW-1:0] p, input int intrude_at, output int cycles);
        start   = 1'b1;
        pattern = p;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = DW'($urandom);
        check("busy_at_start", busy, 1);
        check("done_at_start", done, 0);
        cycles = 0;
        while (!done && cycles < 200) begin
            if (cycles + 1 == intrude_at) begin
                start   = 1'b1;
                pattern = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic verify(input string name, input logic [DW-1:0] p, input int cycles, input int w0);
        int  efc, efa, bad;
        bit  stopped;
        logic [DW-1:0] np;
        model(p, efc, efa);
        stopped = STOP_MODE && (efc > 0);
        if (stopped) efc = 1;
        np = ~p;
        check({name, "_done"}, done, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_pass"}, pass, (efc == 0));
        check({name, "_fail_count"}, fail_count, efc);
        check({name, "_fail_addr"}, fail_addr, efa);
        if (!stopped) begin
            check({name, "_latency"}, cycles, 66);
            check({name, "_writes"}, writes - w0, 32);
            bad = 0;
            for (int a = 0; a < N; a++) begin
                if (mem[a] !== np) bad++;
            end
            check({name, "_mem_bad_words"}, bad, 0);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < N; a++) rmask[a] = 8'hFF;
    endtask

    initial begin
        int cyc, w0;
        logic [DW-1:0] p;

        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_we", ram_write_en, 0);
        check("rst_addr", ram_address, 0);
        check("rst_data_in", ram_data_in, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Clean run
        w0 = writes;
        run_bist(8'hA5, 0, cyc);
        verify("clean", 8'hA5, cyc, w0);

        // Stuck-at-0 on bit 0 of address 7
        rmask[7] = 8'hFE;
        w0 = writes;
        run_bist(8'h00, 0, cyc);
        verify("stuck", 8'h00, cyc, w0);
        clear_faults();

        // Two addresses that always read zero
        rmask[3]  = 8'h00;
        rmask[12] = 8'h00;
        w0 = writes;
        run_bist(8'hF0, 0, cyc);
        verify("multi", 8'hF0, cyc, w0);
        clear_faults();

        // start while busy is ignored
        w0 = writes;
        run_bist(8'h3C, 10, cyc);
        verify("start_busy", 8'h3C, cyc, w0);

        // Back-to-back start from DONE
        check("b2b_pre_done", done, 1);
        w0 = writes;
        run_bist(8'h00, 0, cyc);
        verify("b2b", 8'h00, cyc, w0);

        // Reset in the middle of a run
        start   = 1'b1;
        pattern = 8'h96;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy_before_rst", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_we", ram_write_en, 0);
        check("mid_rst_addr", ram_address, 0);
        check("mid_rst_fail_count", fail_count, 0);
        w0 = writes;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_writes", writes - w0, 0);
        w0 = writes;
        run_bist(8'h5A, 0, cyc);
        verify("after_rst", 8'h5A, cyc, w0);

        // Randomized fault maps and patterns
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < N; a++) begin
                rmask[a] = ($urandom_range(0, 5) == 0) ? DW'($urandom) : 8'hFF;
            end
            p  = DW'($urandom);
            w0 = writes;
            run_bist(p, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0, cyc);
            verify($sformatf("rand%0d", it), p, cyc, w0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
